inst_fetch_unit: RTL

Fetch stage that sits directly upstream of the synchronous instruction ROM in the single-cycle/pipelined MIPS datapath. Owns the PC, drives the ROM address, and tracks the ROM's one-cycle read latency. Presents instruction/PC pairs with a valid flag to decode. Supports decode back-pressure (stall) and branch/jump redirect with no bubble.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/inst_fetch_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_STALL = 2'd3
    } fetch_state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Fetch stage in front of a one-cycle-latency instruction ROM: owns the PC, handles stall and redirect.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_fault_out for misaligned / out-of-range redirects.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] rom_addr_out,
    input  logic [31:0] rom_data_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault_out
`endif
);

    generate
        if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
            $error("inst_fetch_unit: ADDR_WIDTH must be in 1..29");
        end
    endgenerate

    fetch_state_t state_q;
    fetch_state_t state_next;
    fetch_state_t cur_state;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  fetch_pc_next;
    logic [31:0]  resp_pc_q;
    logic [31:0]  resp_pc_next;
    logic [31:0]  redirect_target;
    logic         redirect_bad;
    logic         frozen;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    assign redirect_target = redirect_pc_in;
    assign redirect_bad    = (|redirect_pc_in[1:0]) || (|redirect_pc_in[31:ADDR_WIDTH+2]);
    assign frozen          = fault_q;
    assign fetch_fault_out = fault_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (redirect_in && redirect_bad) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign redirect_target = word_align(redirect_pc_in);
    assign redirect_bad    = 1'b0;
    assign frozen          = 1'b0;
`endif

    // Reset is folded into the decoded state so outputs go quiet in the same cycle.
    assign cur_state = reset ? S_RESET : state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_PRIME;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
        end else begin
            state_q    <= state_next;
            fetch_pc_q <= fetch_pc_next;
            resp_pc_q  <= resp_pc_next;
        end
    end

    always_comb begin
        state_next = cur_state;
        unique case (cur_state)
            S_RESET: state_next = S_PRIME;
            S_PRIME: state_next = S_RUN;
            S_RUN, S_STALL: begin
                if (redirect_in) begin
                    state_next = S_RUN;
                end else if (stall_in) begin
                    state_next = S_STALL;
                end else begin
                    state_next = S_RUN;
                end
            end
        endcase
    end

    always_comb begin
        rom_addr_out  = fetch_pc_q;
        valid_out     = 1'b0;
        fetch_pc_next = fetch_pc_q;
        resp_pc_next  = resp_pc_q;
        if (cur_state == S_RESET) begin
            rom_addr_out = RESET_PC;
        end else begin
            valid_out = ((cur_state == S_RUN) || (cur_state == S_STALL)) && !redirect_in && !frozen;
            if (frozen) begin
                rom_addr_out = fetch_pc_q;
            end else if (redirect_in) begin
                rom_addr_out = redirect_target;
                if (!redirect_bad) begin
                    resp_pc_next  = redirect_target;
                    fetch_pc_next = next_pc(redirect_target);
                end
            end else if ((cur_state != S_PRIME) && stall_in) begin
                // Re-read the displayed word so rom_data_in stays put while decode is busy.
                rom_addr_out = resp_pc_q;
            end else begin
                resp_pc_next  = fetch_pc_q;
                fetch_pc_next = next_pc(fetch_pc_q);
            end
        end
    end

    assign instr_out    = rom_data_in;
    assign pc_out       = resp_pc_q;
    assign pc_plus4_out = next_pc(resp_pc_q);

endmodule
